mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM registers and the MEM/WB control/data registers.
//  Turns a MEM-stage load/store into one data-memory req/ack transaction, with byte enables and store-data lane placement.
//  Sign/zero-extends load data; stalls the pipe while the access is outstanding; flags misaligned/illegal/timed-out accesses.
//  Supplies ReadDataM and a gated RegWrite to the MEM/WB registers.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ waiting for dmem_ack before abort; 1..255 (8-bit counter)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset (asserted when 0)
//  ValidM         in   1   MEM stage holds a real instruction
//  FlushM         in   1   squash current MEM instruction
//  MemReadM       in   1   load
//  MemWriteM      in   1   store
//  Funct3M        in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM     in   32  effective byte address
//  WriteDataM     in   32  store data (rs2)
//  RegWriteM      in   1   register write from EX/MEM
//  dmem_req       out  1   memory request
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word address {addr[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-placed store data
//  dmem_ack       in   1   transaction complete; rdata valid this cycle
//  dmem_rdata     in   32  read word
//  ReadDataM      out  32  extended load result
//  RegWriteMG     out  1   RegWriteM gated by fault/flush; to MEM/WB
//  StallM         out  1   hold IF..MEM stages
//  FaultM         out  1   1-cycle pulse: misaligned, illegal Funct3M or timeout
// BEHAVIOUR
//  acc = ValidM & (MemReadM|MemWriteM) & ~FlushM. Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0.
//  Illegal Funct3M: loads 011/11x; stores anything but 000/001/010.
//  FSM IDLE -> REQ -> DONE -> IDLE; registered state; reset -> IDLE.
//  IDLE:
//   - acc & legal: latch addr/we/be/wdata/funct3, go to REQ; StallM=1 (combinational).
//   - acc & (misaligned|illegal): FaultM=1, RegWriteMG=0, no request, no stall, stay IDLE.
//  REQ:
//   - dmem_req=1, all dmem_* from latched copies, stable until ack; StallM=1; counter++.
//   - On dmem_ack: latch extended rdata into ReadDataM, go to DONE.
//   - counter==TIMEOUT_CYCLES without ack: drop req, FaultM=1, go to DONE with ReadDataM=0.
//  DONE:
//   - StallM=0, so the instruction advances at this edge; RegWriteMG=RegWriteM & ~fault & ~flushed; go to IDLE.
//  Minimum MEM occupancy is 3 cycles (ack in first REQ cycle): StallM high for 2 cycles.
//  Non-memory instruction in IDLE: StallM=0, RegWriteMG=RegWriteM & ~FlushM, 1 cycle.
//  FlushM in REQ: request is not cancelled; hold req until ack/timeout, then discard data; RegWriteMG=0 in DONE.
//  A flush sticky bit is cleared on leaving DONE.
//  dmem_be/wdata:
//   - B: be=1<<addr[1:0], wdata={4{wd[7:0]}}.
//   - H: be=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
//   - W: be=1111, wdata=wd.
//  Load extract: select byte/half by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
//  ReadDataM holds its last value except when updated in REQ.
//  Reset values: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, ReadDataM=0.
//  Also at reset: StallM=0, FaultM=0, RegWriteMG=0.
//  Reset asserted mid-REQ: dmem_req drops asynchronously; the transaction is abandoned.
//  Reset release: IDLE on the next edge.
// TESTING
//  LB addr 0x103, rdata 0x80FF_FF12, ack on first REQ cycle:
//   - ReadDataM=0xFFFFFF80, be=1000, StallM high 2 cycles.
//  LHU addr 0x102, rdata 0xBEEF_0000: ReadDataM=0x0000BEEF. LH at the same address: ReadDataM=0xFFFFBEEF.
//  SH addr 0x202, WriteDataM=0x1234_ABCD, ack after 3 REQ cycles:
//   - dmem_we=1, be=1100, wdata=0xABCDABCD, fields stable until ack.
//  LW addr 0x101:
//   - FaultM pulses 1 cycle, dmem_req never rises, RegWriteMG=0, StallM=0.
//  TIMEOUT_CYCLES=4, no ack:
//   - req high 4 cycles then drops, FaultM=1, ReadDataM=0, RegWriteMG=0.
//  FlushM in REQ, ack later: ack consumed, RegWriteMG=0.
//  Reset low mid-REQ: dmem_req=0 immediately; reset release, then IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory req/ack transaction per load/store,
// with lane placement, load extension, pipeline stall and fault reporting.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        FlushM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        RegWriteM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        RegWriteMG,
  output logic        StallM,
  output logic        FaultM
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        flush_q, flush_d, fault_q, fault_d;

  logic        acc, illegal, misaligned, latch_en, timeout;
  logic        stall, fault, rwg;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign acc = ValidM & (MemReadM | MemWriteM) & ~FlushM;

  always_comb begin
    if (MemWriteM) illegal = Funct3M[2] | (&Funct3M[1:0]);
    else           illegal = (Funct3M == 3'b011) | (&Funct3M[2:1]);
    misaligned = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                 ((Funct3M[1:0] == 2'b10) & (|ALUResultM[1:0]));
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALUResultM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the latched offset/size so it matches the issued request.
  always_comb begin
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  assign timeout = (state_q == StReq) && (cnt_q == TimeoutCnt);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    flush_d  = flush_q;
    fault_d  = fault_q;
    latch_en = 1'b0;
    stall    = 1'b0;
    fault    = 1'b0;
    rwg      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc && (illegal || misaligned)) begin
          fault = 1'b1;
        end else if (acc) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          cnt_d    = 8'd0;
          flush_d  = 1'b0;
          fault_d  = 1'b0;
          state_d  = StReq;
        end else begin
          rwg = RegWriteM & ~FlushM;
        end
      end
      StReq: begin
        stall   = 1'b1;
        flush_d = flush_q | FlushM;
        if (timeout) begin
          fault   = 1'b1;
          fault_d = 1'b1;
          rdata_d = 32'h0;
          state_d = StDone;
        end else if (dmem_ack) begin
          // A flushed access still completes on the bus, but its data is dropped.
          if (!(flush_q | FlushM)) rdata_d = load_ext;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        rwg     = RegWriteM & ~fault_q & ~flush_q & ~FlushM;
        flush_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      flush_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        we_q     <= MemWriteM;
        addr_q   <= {ALUResultM[31:2], 2'b00};
        be_q     <= be_new;
        wdata_q  <= wdata_new;
        funct3_q <= Funct3M;
        off_q    <= ALUResultM[1:0];
      end
    end
  end

  assign dmem_req   = (state_q == StReq) & ~timeout;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign ReadDataM  = rdata_q;
  // Held at zero while reset is asserted, whatever the pipeline drives.
  assign StallM     = stall & reset;
  assign FaultM     = fault & reset;
  assign RegWriteMG = rwg & reset;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver pushes expectations from a reference
// model, a memory responder acks requests, a monitor pops and compares.
module tb_mem_stage_lsu;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, FlushM, MemReadM, MemWriteM, RegWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ReadDataM;
  logic [3:0]  dmem_be;
  logic        RegWriteMG, StallM, FaultM;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .FlushM(FlushM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RegWriteM(RegWriteM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM),
    .RegWriteMG(RegWriteMG), .StallM(StallM), .FaultM(FaultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } bus_t;

  typedef struct {
    bit          fault;
    bit          rwg;
    int          stall;
    int          reqc;
    bit          chk_rd;
    logic [31:0] rd;
  } wb_t;

  bus_t        bus_q[$];
  wb_t         wb_q[$];
  int          lat_q[$];
  logic [31:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: size/sign rules expressed with plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    longint v;
    int sh;
    sh = (a % 4) * 8;
    case (f3)
      3'd0: begin v = (w >> sh) % 256; if (v >= 128) v = v - 256; end
      3'd4: v = (w >> sh) % 256;
      3'd1: begin v = (w >> ((a % 4 >= 2) ? 16 : 0)) % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = (w >> ((a % 4 >= 2) ? 16 : 0)) % 65536;
      default: v = w;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3 % 4)
      0: return 4'(1 << (a % 4));
      1: return (a % 4 >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3 % 4)
      0: return (wd % 256) * 32'h0101_0101;
      1: return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // kind: 0 non-memory, 1 load, 2 store; lat: REQ cycle of ack (0 = never)
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit rw, input int lat, input bit fl);
    bit legal, misal, to, adv;
    wb_t w;
    bus_t b;
    int n;
    legal = (kind == 2) ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    misal = ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0));
    w = '{fault: 0, rwg: 0, stall: 0, reqc: 0, chk_rd: 0, rd: 0};
    if (kind == 0) begin
      w.rwg = rw && !fl;
    end else if (!legal || misal) begin
      w.fault = 1;
    end else begin
      to       = (lat == 0) || (lat > int'(T));
      w.fault  = to;
      w.rwg    = rw && !to && !fl;
      w.reqc   = to ? int'(T) : lat;
      w.stall  = to ? int'(T) + 2 : lat + 1;
      w.chk_rd = (kind == 1) && !fl;
      w.rd     = to ? 32'h0 : ref_load(f3, a, mem[a[9:2]]);
      b = '{we: (kind == 2), addr: a - (a % 4), be: ref_be(f3, a),
            wdata: ref_wdata(f3, wd), chk_wdata: (kind == 2)};
      bus_q.push_back(b);
      lat_q.push_back(lat);
    end
    wb_q.push_back(w);
    ValidM = 1'b1; MemReadM = (kind == 1); MemWriteM = (kind == 2);
    Funct3M = f3; ALUResultM = a; WriteDataM = wd; RegWriteM = rw;
    FlushM = (kind == 0) ? fl : 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      adv = !StallM;
      @(posedge clk); #1;
      n++;
      if (adv) break;
      if (n == 1 && fl) FlushM = 1'b1;
      if (n > 30) begin
        n_chk++; n_fail++;
        $display("FAIL txn_complete: still stalled after %0d cycles, expected release", n);
        break;
      end
    end
    ValidM = 1'b0; FlushM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Memory responder: acks in the lat-th cycle of each request.
  initial begin
    int cyc, cur_lat;
    bit busy;
    busy = 0; cyc = 0; cur_lat = 0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset && dmem_req) begin
        if (!busy) begin
          busy = 1; cyc = 0;
          if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
          else begin
            cur_lat = 0; n_chk++; n_fail++;
            $display("FAIL unexpected_req: addr %h, expected no request", dmem_addr);
          end
        end
        cyc++;
        dmem_ack   = (cyc == cur_lat);
        dmem_rdata = (cyc == cur_lat) ? mem[dmem_addr[9:2]] : $urandom;
      end else begin
        busy = 0; dmem_ack = 1'b0;
      end
    end
  end

  // Monitor: checks request fields and every instruction leaving MEM.
  initial begin
    int m_fault, m_stall, m_req;
    bit req_prev;
    bus_t cur;
    wb_t w;
    m_fault = 0; m_stall = 0; m_req = 0; req_prev = 0;
    cur = '{we: 0, addr: 0, be: 0, wdata: 0, chk_wdata: 0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_fault = 0; m_stall = 0; m_req = 0; req_prev = 0;
      end else begin
        m_fault += int'(FaultM);
        m_stall += int'(StallM);
        if (dmem_req) begin
          m_req++;
          if (!req_prev) begin
            if (bus_q.size() > 0) cur = bus_q.pop_front();
            check("req_we", 96'(dmem_we), 96'(cur.we));
            check("req_addr", 96'(dmem_addr), 96'(cur.addr));
            check("req_be", 96'(dmem_be), 96'(cur.be));
            if (cur.chk_wdata) check("req_wdata", 96'(dmem_wdata), 96'(cur.wdata));
          end else begin
            check("req_stable", {dmem_we, dmem_addr, dmem_be, cur.chk_wdata ? dmem_wdata : 32'h0},
                  {cur.we, cur.addr, cur.be, cur.chk_wdata ? cur.wdata : 32'h0});
          end
        end
        req_prev = dmem_req;
        if (ValidM && !StallM) begin
          if (wb_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL wb_unexpected: completion seen, expected none");
          end else begin
            w = wb_q.pop_front();
            check("fault_pulses", 96'(m_fault), 96'(w.fault ? 1 : 0));
            check("regwrite_g", 96'(RegWriteMG), 96'(w.rwg));
            check("stall_cycles", 96'(m_stall), 96'(w.stall));
            check("req_cycles", 96'(m_req), 96'(w.reqc));
            if (w.chk_rd) check("read_data", 96'(ReadDataM), 96'(w.rd));
          end
          m_fault = 0; m_stall = 0; m_req = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, lat, sz;
    logic [2:0] f3;
    logic [31:0] a;
    reset = 1'b0; ValidM = 1'b0; FlushM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    Funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0; RegWriteM = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #1;
    check("rst_req", 96'(dmem_req), 96'(0));
    check("rst_bus", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, 96'(0));
    check("rst_rdata", 96'(ReadDataM), 96'(0));
    check("rst_outs", {StallM, FaultM, RegWriteMG}, 96'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    mem[8'h40] = 32'h80FF_FF12;
    run_txn(1, 3'd0, 32'h103, 32'h0, 1'b1, 1, 1'b0);
    check("lb_0x103", 96'(ReadDataM), 96'(32'hFFFF_FF80));
    mem[8'h40] = 32'hBEEF_0000;
    run_txn(1, 3'd5, 32'h102, 32'h0, 1'b1, 2, 1'b0);
    check("lhu_0x102", 96'(ReadDataM), 96'(32'h0000_BEEF));
    run_txn(1, 3'd1, 32'h102, 32'h0, 1'b1, 1, 1'b0);
    check("lh_0x102", 96'(ReadDataM), 96'(32'hFFFF_BEEF));
    run_txn(2, 3'd1, 32'h202, 32'h1234_ABCD, 1'b0, 3, 1'b0);
    run_txn(1, 3'd2, 32'h101, 32'h0, 1'b1, 1, 1'b0);
    run_txn(1, 3'd2, 32'h200, 32'h0, 1'b1, 0, 1'b0);
    check("timeout_rdata", 96'(ReadDataM), 96'(0));
    run_txn(1, 3'd2, 32'h204, 32'h0, 1'b1, 3, 1'b1);
    run_txn(0, 3'd0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    run_txn(0, 3'd0, 32'h0, 32'h0, 1'b1, 0, 1'b1);
    run_txn(1, 3'd3, 32'h300, 32'h0, 1'b1, 1, 1'b0);
    run_txn(2, 3'd4, 32'h300, 32'h5, 1'b0, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      kind = ($urandom % 10 < 2) ? 0 : (($urandom % 2 == 0) ? 1 : 2);
      if ($urandom % 4 != 0) begin
        sz = $urandom % 3;
        f3 = 3'(sz);
        if (kind == 1 && sz < 2 && $urandom % 2 == 1) f3 = 3'(sz + 4);
      end else begin
        f3 = 3'($urandom % 8);
      end
      a = 32'($urandom_range(0, 1023));
      if ($urandom % 4 != 0) a = (f3 % 4 == 2) ? a - (a % 4) : ((f3 % 4 == 1) ? a - (a % 2) : a);
      lat = ($urandom % 10 == 0) ? 0 : $urandom_range(1, T);
      run_txn(kind, f3, a, $urandom, 1'($urandom % 2), lat, ($urandom % 8 == 0));
      if ($urandom % 3 == 0) begin @(posedge clk); #1; end
    end

    // Reset asserted while a request is outstanding.
    bus_q.push_back('{we: 0, addr: 32'h100, be: 4'hF, wdata: 0, chk_wdata: 0});
    lat_q.push_back(0);
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
    ALUResultM = 32'h100; RegWriteM = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("req_before_reset", 96'(dmem_req), 96'(1));
    reset = 1'b0; ValidM = 1'b0; MemReadM = 1'b0;
    #1;
    check("reset_drops_req", 96'(dmem_req), 96'(0));
    check("reset_outs", {StallM, FaultM, RegWriteMG}, 96'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {dmem_req, StallM}, 96'(0));
    mem[8'h50] = 32'h1122_8344;
    run_txn(1, 3'd4, 32'h141, 32'h0, 1'b1, 1, 1'b0);
    check("lbu_after_reset", 96'(ReadDataM), 96'(32'h0000_0083));

    repeat (3) @(posedge clk);
    #1 check("wb_queue_drained", 96'(wb_q.size()), 96'(0));
    check("bus_queue_drained", 96'(bus_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
